// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs one multiply or divide on behalf of the main control unit.
// It screens div requests for a zero divisor, starts the selected unit and waits
// for its stop flag under a watchdog. It then commits the result by steering the
// HI/LO muxes and pulsing both load enables.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   op_start, op_sel      request pulse and unit select (0 = mult, 1 = div), sampled in IDLE
//   divisor               B register value, tested for zero on div requests
//   mult_stop, div_stop   unit completion flags, sampled only in WAIT
//   mult_init, div_init   one-cycle unit start pulses
//   hilo_sel              HI/LO mux select (0 = mult, 1 = div), holds between operations
//   high_load, low_load   HI/LO load enables
//   busy                  high outside IDLE
//   done                  result committed
//   div_zero_exc          div request rejected for zero divisor
//   timeout_err           unit missed its watchdog deadline
module muldiv_sequencer #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [31:0] divisor,
    input  logic        mult_stop,
    input  logic        div_stop,
    output logic        mult_init,
    output logic        div_init,
    output logic        hilo_sel,
    output logic        high_load,
    output logic        low_load,
    output logic        busy,
    output logic        done,
    output logic        div_zero_exc,
    output logic        timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StWait,
        StWrite,
        StExc,
        StErr
    } state_e;

    state_e          state_q, state_d;
    logic            op_q, op_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            sel_stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Only the selected unit's completion flag matters.
    assign sel_stop = op_q ? div_stop : mult_stop;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (op_start) begin
                    op_d = op_sel;
                    if (op_sel && (divisor == 32'h0)) begin
                        state_d = StExc;
                    end else begin
                        state_d = StInit;
                    end
                end
            end
            StInit: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                // Stop takes priority over an expiring watchdog in the same cycle.
                if (sel_stop) begin
                    state_d = StWrite;
                end else if (cnt_q == CntLast) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: state_d = StIdle;
            StExc:   state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend only on registered state, so request/stop inputs never reach them.
    always_comb begin
        mult_init    = (state_q == StInit) && !op_q;
        div_init     = (state_q == StInit) && op_q;
        hilo_sel     = op_q;
        high_load    = (state_q == StWrite);
        low_load     = (state_q == StWrite);
        done         = (state_q == StWrite);
        busy         = (state_q != StIdle);
        div_zero_exc = (state_q == StExc);
        timeout_err  = (state_q == StErr);
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer. Two instances share all inputs: one with the
// default TIMEOUT (64) and one with TIMEOUT = 8, so one stop timing exercises both a
// completion and a watchdog expiry. Each request pushes a predicted outcome per
// instance; a negedge monitor pops and compares whenever an instance reports.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        op_start;
    logic        op_sel;
    logic [31:0] divisor;
    logic        mult_stop;
    logic        div_stop;

    logic mi_a, di_a, hs_a, hl_a, ll_a, bs_a, dn_a, ex_a, er_a;
    logic mi_b, di_b, hs_b, hl_b, ll_b, bs_b, dn_b, ex_b, er_b;
    logic [8:0] out_a, out_b;

    assign out_a = {mi_a, di_a, hs_a, hl_a, ll_a, bs_a, dn_a, ex_a, er_a};
    assign out_b = {mi_b, di_b, hs_b, hl_b, ll_b, bs_b, dn_b, ex_b, er_b};

    muldiv_sequencer #(.TIMEOUT(64)) dut_a (
        .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel), .divisor(divisor),
        .mult_stop(mult_stop), .div_stop(div_stop), .mult_init(mi_a), .div_init(di_a),
        .hilo_sel(hs_a), .high_load(hl_a), .low_load(ll_a), .busy(bs_a), .done(dn_a),
        .div_zero_exc(ex_a), .timeout_err(er_a)
    );

    muldiv_sequencer #(.TIMEOUT(8)) dut_b (
        .clk(clk), .reset(reset), .op_start(op_start), .op_sel(op_sel), .divisor(divisor),
        .mult_stop(mult_stop), .div_stop(div_stop), .mult_init(mi_b), .div_init(di_b),
        .hilo_sel(hs_b), .high_load(hl_b), .low_load(ll_b), .busy(bs_b), .done(dn_b),
        .div_zero_exc(ex_b), .timeout_err(er_b)
    );

    always #5 clk = ~clk;

    // kind: 0 = done, 1 = div-zero exception, 2 = timeout error
    // init_kind: 0 = none, 1 = mult_init, 2 = div_init
    typedef struct {
        int kind;
        bit op;
        int init_kind;
        int init_at;
        int evt_at;
    } item_t;

    item_t q0[$];
    item_t q1[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    int    loads_seen = 0;
    bit    exp_op[2];
    bit    after_evt[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input int d, input longint act,
                       input longint exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s dut%0d at cycle %0d: got %0d, expected %0d", name, d, cyc, act,
                     exp);
        end
    endtask

    // Reference model: outcome of one request, with cycles counted from the edge that
    // samples op_start (cycle 1 follows it). j is the WAIT cycle (1-based) in which the
    // selected unit raises stop; 0 means never.
    function automatic item_t predict(input bit op, input logic [31:0] dv, input int j,
                                      input int t, input int issue);
        item_t it;
        it.op      = op;
        it.init_at = issue + 1;
        if (op && dv == 32'h0) begin
            it.kind      = 1;
            it.init_kind = 0;
            it.evt_at    = issue + 1;
        end else begin
            it.init_kind = op ? 2 : 1;
            if (j >= 1 && j <= t) begin
                it.kind   = 0;
                it.evt_at = issue + j + 2;
            end else begin
                it.kind   = 2;
                it.evt_at = issue + t + 2;
            end
        end
        return it;
    endfunction

    task automatic mon(input int d, input logic [8:0] o);
        item_t      it;
        bit         have;
        logic [2:0] ev;
        logic [2:0] ev_exp;
        have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
        if (have) begin
            if (d == 0) it = q0[0];
            else it = q1[0];
        end
        ev = o[2:0];
        if (o[8] | o[7]) begin
            if (!have) begin
                chk(1'b0, "init_unexpected", d, int'({o[8], o[7]}), 0);
            end else begin
                chk({o[8], o[7]} == ((it.init_kind == 1) ? 2'b10 :
                                     (it.init_kind == 2) ? 2'b01 : 2'b00),
                    "init_kind", d, int'({o[8], o[7]}), it.init_kind);
                chk(cyc == it.init_at, "init_cycle", d, cyc, it.init_at);
            end
        end
        if (ev != 3'b000 || o[5] || o[4]) begin
            if (o[5] | o[4]) loads_seen++;
            if (!have) begin
                chk(1'b0, "event_unexpected", d, int'({o[5], o[4], ev}), 0);
            end else begin
                if (d == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                ev_exp = (it.kind == 0) ? 3'b100 : (it.kind == 1) ? 3'b010 : 3'b001;
                chk(ev == ev_exp, "event_kind", d, ev, ev_exp);
                chk(cyc == it.evt_at, "event_cycle", d, cyc, it.evt_at);
                chk({o[5], o[4]} == ((it.kind == 0) ? 2'b11 : 2'b00), "hilo_loads", d,
                    {o[5], o[4]}, (it.kind == 0) ? 3 : 0);
                if (it.kind == 0) chk(o[6] == it.op, "hilo_sel_write", d, o[6], it.op);
                exp_op[d]    = it.op;
                after_evt[d] = 1'b1;
            end
        end else begin
            if (after_evt[d]) begin
                chk(o[3] == 1'b0, "busy_after_event", d, o[3], 0);
                after_evt[d] = 1'b0;
            end
            if (!o[3]) chk(o[6] == exp_op[d], "hilo_sel_idle", d, o[6], exp_op[d]);
            else if (have) chk(o[6] == it.op, "hilo_sel_busy", d, o[6], it.op);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            // Reset abandons anything in flight.
            q0.delete();
            q1.delete();
            exp_op[0]    = 1'b0;
            exp_op[1]    = 1'b0;
            after_evt[0] = 1'b0;
            after_evt[1] = 1'b0;
        end else begin
            mon(0, out_a);
            mon(1, out_b);
        end
    end

    // One request. Entered 2 time units after a rising edge; returns at the same phase
    // once both instances are back in IDLE, so the next call is back-to-back.
    // oj: cycle of a stop pulse from the unselected unit; rej: cycle of a rejected request.
    task automatic run_txn(input bit op, input logic [31:0] dv, input int j, input int oj,
                           input int rej);
        item_t pa, pb;
        int    issue, len;
        issue = cyc;
        pa = predict(op, dv, j, 64, issue);
        pb = predict(op, dv, j, 8, issue);
        q0.push_back(pa);
        q1.push_back(pb);
        len = ((pa.evt_at > pb.evt_at) ? pa.evt_at : pb.evt_at) - issue;
        op_start = 1'b1;
        op_sel   = op;
        divisor  = dv;
        @(posedge clk); #2;
        op_start = 1'b0;
        op_sel   = 1'($urandom);
        divisor  = $urandom;
        for (int c = 1; c <= len; c++) begin
            @(posedge clk); #2;
            mult_stop = op ? (c == oj) : (c == j);
            div_stop  = op ? (c == j) : (c == oj);
            op_start  = (rej != 0) && (c == rej);
            if (c == rej) op_sel = ~op;
        end
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        op_start  = 1'b0;
        chk(q0.size() == 0, "drain", 0, q0.size(), 0);
        chk(q1.size() == 0, "drain", 1, q1.size(), 0);
    endtask

    task automatic reset_mid_wait();
        int issue, loads_before;
        issue = cyc;
        q0.push_back(predict(1'b1, 32'd3, 0, 64, issue));
        q1.push_back(predict(1'b1, 32'd3, 0, 8, issue));
        op_start = 1'b1;
        op_sel   = 1'b1;
        divisor  = 32'd3;
        @(posedge clk); #2;
        op_start = 1'b0;
        repeat (4) begin
            @(posedge clk); #2;
        end
        reset = 1'b1;
        #1;
        chk(out_a == 9'h0, "reset_mid_wait_outputs", 0, out_a, 0);
        chk(out_b == 9'h0, "reset_mid_wait_outputs", 1, out_b, 0);
        loads_before = loads_seen;
        @(posedge clk); #2;
        reset = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #2;
            div_stop  = (c <= 3);
            mult_stop = (c <= 3);
        end
        div_stop  = 1'b0;
        mult_stop = 1'b0;
        chk(loads_seen == loads_before, "no_load_after_reset", 0, loads_seen, loads_before);
        chk(!bs_a && !bs_b, "idle_after_reset", 0, int'({bs_a, bs_b}), 0);
    endtask

    initial begin
        reset     = 1'b1;
        op_start  = 1'b0;
        op_sel    = 1'b0;
        divisor   = 32'h0;
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        #1;
        chk(out_a == 9'h0, "reset_outputs", 0, out_a, 0);
        chk(out_b == 9'h0, "reset_outputs", 1, out_b, 0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;

        run_txn(1'b0, 32'd5, 33, 0, 0);  // mult, stop after 33 WAIT cycles
        run_txn(1'b1, 32'd7, 1, 0, 0);   // div, minimum latency
        run_txn(1'b1, 32'd0, 2, 0, 0);   // div by zero
        run_txn(1'b0, 32'd9, 0, 3, 0);   // mult never stops, stray div_stop
        run_txn(1'b0, 32'd11, 10, 0, 4); // second request while busy
        run_txn(1'b1, 32'd13, 8, 0, 0);  // stop on last WAIT cycle of TIMEOUT = 8
        run_txn(1'b0, 32'd14, 9, 0, 0);  // one cycle too late for TIMEOUT = 8
        run_txn(1'b1, 32'd15, 64, 0, 0); // stop on last WAIT cycle of TIMEOUT = 64
        run_txn(1'b0, 32'd16, 65, 0, 0); // one cycle too late for TIMEOUT = 64

        for (int n = 0; n < 25; n++) begin
            bit          op;
            logic [31:0] dv;
            op = 1'($urandom_range(0, 1));
            dv = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            run_txn(op, dv, int'($urandom_range(0, 70)), int'($urandom_range(0, 70)), 0);
        end

        reset_mid_wait();
        run_txn(1'b1, 32'd21, 5, 0, 0);  // normal operation resumes after reset

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end

endmodule
